// File: rtl/mux_n_to_1_reg.sv
// mux_n_to_1_reg: registered N:1 valid/ready mux with explicit-select or round-robin grant.
// Optional macro MUX_SEL_ERR_EN adds a registered sel_err flag for out-of-range sel in MODE=0.
module mux_n_to_1_reg #(
  parameter int SIZE     = 16,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int MODE     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CHANNELS*SIZE-1:0] in_data,
  input  logic [CHANNELS-1:0]      in_valid,
  output logic [CHANNELS-1:0]      in_ready,
  input  logic [SEL_W-1:0]         sel,
  output logic [SIZE-1:0]          out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef MUX_SEL_ERR_EN
  output logic [SEL_W-1:0]         out_chan,
  output logic                     sel_err
`else
  output logic [SEL_W-1:0]         out_chan
`endif
);

  logic [SIZE-1:0]          r_data;
  logic                     r_valid;
  logic [SEL_W-1:0]         r_chan;
  logic [SEL_W-1:0]         r_last;
  logic                     w_load;
  logic                     w_sel_ok;
  logic                     w_sel_hit;
  logic [CHANNELS-1:0]      w_vshift;
  logic                     w_rr_hit;
  logic [SEL_W-1:0]         w_rr_g;
  logic                     w_grant;
  logic [SEL_W-1:0]         w_g;
  logic [CHANNELS*SIZE-1:0] w_dshift;
  logic [SIZE-1:0]          w_data;

  assign w_load    = !r_valid || out_ready;
  assign w_sel_ok  = int'(sel) < CHANNELS;
  assign w_vshift  = in_valid >> sel;
  assign w_sel_hit = w_sel_ok && w_vshift[0];

  // Round-robin search starting just after the last winner; descending loop lets the nearest requester win.
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_g   = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      int j;
      j = (int'(r_last) + k) % CHANNELS;
      if (in_valid[j]) begin
        w_rr_hit = 1'b1;
        w_rr_g   = SEL_W'(j);
      end
    end
  end

  assign w_grant  = (MODE == 1) ? w_rr_hit : w_sel_hit;
  assign w_g      = (MODE == 1) ? w_rr_g : sel;
  assign w_dshift = in_data >> (SIZE * int'(w_g));
  assign w_data   = w_dshift[SIZE-1:0];

  // Reset suppresses any accept so a producer never sees a handshake that is then dropped.
  assign in_ready = (rst_n && w_load && w_grant) ? (CHANNELS'(1) << w_g) : '0;

  // Output register stage; pointer only moves on an actual transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_chan  <= '0;
      r_last  <= SEL_W'(CHANNELS - 1);
    end else if (w_load) begin
      r_valid <= w_grant;
      if (w_grant) begin
        r_data <= w_data;
        r_chan <= w_g;
        if (MODE == 1) r_last <= w_g;
      end
    end
  end

`ifdef MUX_SEL_ERR_EN
  // One-cycle flag whenever an out-of-range select is presented while the stage could load.
  always_ff @(posedge clk) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= (MODE == 0) && w_load && !w_sel_ok;
  end
`endif

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_chan  = r_chan;

endmodule

// File: tb/tb_mux_n_to_1_reg.sv
// tb_mux_n_to_1_reg: directed checks of select, backpressure and round-robin behaviour.
module tb_mux_n_to_1_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  logic [63:0] d0 = '0; logic [3:0] v0 = '0; logic [3:0] ir0; logic [1:0] s0 = '0;
  logic [15:0] od0; logic ov0; logic rdy0 = 1'b0; logic [1:0] oc0;
  logic [63:0] d1 = '0; logic [3:0] v1 = '0; logic [3:0] ir1; logic [1:0] s1 = '0;
  logic [15:0] od1; logic ov1; logic rdy1 = 1'b0; logic [1:0] oc1;
  logic [47:0] d2 = '0; logic [2:0] v2 = '0; logic [2:0] ir2; logic [1:0] s2 = '0;
  logic [15:0] od2; logic ov2; logic rdy2 = 1'b0; logic [1:0] oc2;
  logic [47:0] d3 = '0; logic [2:0] v3 = '0; logic [2:0] ir3; logic [1:0] s3 = '0;
  logic [15:0] od3; logic ov3; logic rdy3 = 1'b0; logic [1:0] oc3;
`ifdef MUX_SEL_ERR_EN
  logic se0, se1, se2, se3;
`endif

  mux_n_to_1_reg #(.SIZE(16), .CHANNELS(4), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(ir0), .sel(s0),
    .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
`ifdef MUX_SEL_ERR_EN
    .sel_err(se0),
`endif
    .out_chan(oc0));

  mux_n_to_1_reg #(.SIZE(16), .CHANNELS(4), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(ir1), .sel(s1),
    .out_data(od1), .out_valid(ov1), .out_ready(rdy1),
`ifdef MUX_SEL_ERR_EN
    .sel_err(se1),
`endif
    .out_chan(oc1));

  mux_n_to_1_reg #(.SIZE(16), .CHANNELS(3), .MODE(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(ir2), .sel(s2),
    .out_data(od2), .out_valid(ov2), .out_ready(rdy2),
`ifdef MUX_SEL_ERR_EN
    .sel_err(se2),
`endif
    .out_chan(oc2));

  mux_n_to_1_reg #(.SIZE(16), .CHANNELS(3), .MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3), .in_valid(v3), .in_ready(ir3), .sel(s3),
    .out_data(od3), .out_valid(ov3), .out_ready(rdy3),
`ifdef MUX_SEL_ERR_EN
    .sel_err(se3),
`endif
    .out_chan(oc3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with all channels requesting
    d0 = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};
    v0 = 4'b1111; rdy0 = 1'b1; s0 = 2'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ov", 32'(ov0), 32'd0);
      chk("rst_od", 32'(od0), 32'd0);
      chk("rst_oc", 32'(oc0), 32'd0);
      chk("rst_ir", 32'(ir0), 32'd0);
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_ir", 32'(ir0), 32'b0001);
    tick();
    chk("post_rst_ov", 32'(ov0), 32'd1);
    chk("post_rst_od", 32'(od0), 32'hA0A0);
    chk("post_rst_oc", 32'(oc0), 32'd0);

    // explicit select of channel 2
    d0 = {16'h0000, 16'hBEEF, 16'h0000, 16'h0000};
    v0 = 4'b0100; s0 = 2'd2;
    #1;
    chk("sel2_ir", 32'(ir0), 32'b0100);
    tick();
    chk("sel2_od", 32'(od0), 32'hBEEF);
    chk("sel2_oc", 32'(oc0), 32'd2);
    chk("sel2_ov", 32'(ov0), 32'd1);
    s0 = 2'd1;
    #1;
    chk("sel1_ir", 32'(ir0), 32'd0);
    tick();
    chk("sel1_ov", 32'(ov0), 32'd0);
    chk("sel1_od_hold", 32'(od0), 32'hBEEF);
    chk("sel1_oc_hold", 32'(oc0), 32'd2);

    // backpressure, then drain and fill on the same edge
    s0 = 2'd0; v0 = 4'b0001; d0 = {48'h0, 16'h1234};
    tick();
    chk("bp_load_od", 32'(od0), 32'h1234);
    rdy0 = 1'b0; d0 = {48'h0, 16'h5555};
    #1;
    chk("bp_ir0", 32'(ir0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_od", 32'(od0), 32'h1234);
      chk("bp_hold_ov", 32'(ov0), 32'd1);
      chk("bp_hold_ir", 32'(ir0), 32'd0);
    end
    rdy0 = 1'b1;
    #1;
    chk("bp_rel_ir", 32'(ir0), 32'b0001);
    tick();
    chk("bp_fill_od", 32'(od0), 32'h5555);
    chk("bp_fill_ov", 32'(ov0), 32'd1);
    v0 = 4'b0000;
    tick();
    chk("bp_idle_ov", 32'(ov0), 32'd0);

    // out-of-range select on a 3-channel instance
    d3 = {16'h3333, 16'h2222, 16'h1111}; v3 = 3'b111; rdy3 = 1'b1; s3 = 2'd3;
    #1;
    chk("oor_ir", 32'(ir3), 32'd0);
    tick();
    chk("oor_ov", 32'(ov3), 32'd0);
`ifdef MUX_SEL_ERR_EN
    chk("oor_err", 32'(se3), 32'd1);
`endif
    s3 = 2'd0;
    #1;
    chk("oor_rec_ir", 32'(ir3), 32'b001);
    tick();
    chk("oor_rec_ov", 32'(ov3), 32'd1);
    chk("oor_rec_od", 32'(od3), 32'h1111);
`ifdef MUX_SEL_ERR_EN
    chk("oor_err_clr", 32'(se3), 32'd0);
`endif

    // round robin over 4 channels, all requesting
    d1 = {16'h1003, 16'h1002, 16'h1001, 16'h1000}; v1 = 4'b1111; rdy1 = 1'b1;
    #1;
    chk("rr_first_ir", 32'(ir1), 32'b0001);
    begin
      logic [1:0] seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("rr_all_oc", 32'(oc1), 32'(seq[i]));
        chk("rr_all_od", 32'(od1), 32'h1000 + 32'(seq[i]));
      end
    end
    v1 = 4'b1010;
    begin
      logic [1:0] seq2 [3] = '{2'd1, 2'd3, 2'd1};
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("rr_1010_oc", 32'(oc1), 32'(seq2[i]));
      end
    end

    // round robin over 3 channels with stalls
    d2 = {16'h2002, 16'h2001, 16'h2000}; v2 = 3'b111; rdy2 = 1'b1;
    tick();
    chk("rr3_oc0", 32'(oc2), 32'd0);
    rdy2 = 1'b0;
    #1;
    chk("rr3_stall_ir", 32'(ir2), 32'd0);
    tick();
    chk("rr3_hold1", 32'(oc2), 32'd0);
    tick();
    chk("rr3_hold2", 32'(oc2), 32'd0);
    chk("rr3_hold_ov", 32'(ov2), 32'd1);
    rdy2 = 1'b1;
    tick();
    chk("rr3_oc1", 32'(oc2), 32'd1);
    tick();
    chk("rr3_oc2", 32'(oc2), 32'd2);
    chk("rr3_od2", 32'(od2), 32'h2002);
    tick();
    chk("rr3_wrap", 32'(oc2), 32'd0);
    chk("rr3_wrap_od", 32'(od2), 32'h2000);

    // reset drops a held word
    rdy0 = 1'b0; v0 = 4'b0001; s0 = 2'd0; d0 = {48'h0, 16'h7777};
    tick();
    chk("rst2_pre_ov", 32'(ov0), 32'd1);
    rst_n = 1'b0; rdy0 = 1'b1;
    #1;
    chk("rst2_ir", 32'(ir0), 32'd0);
    tick();
    chk("rst2_ov", 32'(ov0), 32'd0);
    chk("rst2_od", 32'(od0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_to_1_reg.md
Name: mux_n_to_1_reg

Overview:
- Registered, parameterised N:1 datapath multiplexer; successor to the combinational 2:1 select mux.
- Selects one of CHANNELS input streams, each with a valid/ready handshake.
- Selection is by explicit select (MODE=0) or round-robin arbitration (MODE=1).
- Result drives one output register stage with valid/ready. Used where several producers (ALU result, memory read, immediate path) share one downstream consumer.

Parameters:
- SIZE, 16, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; legal range 2..16, need not be a power of two.
- SEL_W, $clog2(CHANNELS), width of sel and out_chan.
- MODE, 0, 0 = explicit select via sel; 1 = round-robin arbitration over in_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- in_data  input  CHANNELS*SIZE  flattened inputs; channel i occupies bits [i*SIZE +: SIZE].
- in_valid  input  CHANNELS  per-channel data-valid.
- in_ready  output  CHANNELS  per-channel accept; combinational.
- sel  input  SEL_W  channel select, used only when MODE=0.
- out_data  output  SIZE  registered selected data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_chan  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_data=0, out_valid=0, out_chan=0.
  - Round-robin pointer last=CHANNELS-1, so channel 0 has first priority.
  - Reset overrides any in-flight transfer. The held word is dropped, with no in_ready pulse that cycle.
- Load condition: load = !out_valid || out_ready. The output register may take a new word only when load=1.
- Grant g (combinational):
  - MODE=0: g=sel if sel<CHANNELS and in_valid[sel]=1; otherwise no grant.
  - MODE=1: first i with in_valid[i]=1, searching (last+1) mod CHANNELS upward with wrap-around; no grant if all in_valid=0.
- Ready generation: in_ready[i] = load && granted && (g==i). At most one in_ready is high per cycle. in_ready never depends on out_valid of the same cycle except through load.
- Transfer on clk edge with load=1 and grant:
  - out_data<=in_data[g], out_chan<=g, out_valid<=1.
  - MODE=1 only: last<=g.
- Clk edge with load=1 and no grant: out_valid<=0; out_data and out_chan hold their values.
- Clk edge with load=0 (out_valid=1 and out_ready=0): all output registers hold. in_ready is all zero. Producers must hold their data.
- Latency and throughput: latency 1 cycle from input transfer to out_valid. Throughput 1 word/cycle while out_ready=1.
- Simultaneous drain and fill: out_ready=1 while out_valid=1 in the same cycle as a grant. The old word is consumed and the new word is loaded on the same edge, with no bubble.
- Round-robin pointer: updates only on a transfer. Stalls and idle cycles never advance it, so the winner after a stall is deterministic.
- Width: no arithmetic on data. Pointer increment wraps modulo CHANNELS, not 2^SEL_W.
- Out-of-range sel (sel>=CHANNELS, MODE=0): treated as no grant.

Optional Feature:
- Macro: MUX_SEL_ERR_EN.
- Defined:
  - Adds output port sel_err (1 bit, registered, reset 0).
  - On each clk edge where MODE=0, load=1 and sel>=CHANNELS, sel_err<=1 for one cycle; otherwise sel_err<=0.
  - In MODE=1, sel_err is tied 0.
- Not defined:
  - Port absent.
  - Out-of-range sel is silently a no-grant, as in Behaviour.

Test Plan:
- Reset: MODE=0, CHANNELS=4. Drive rst_n=0 for 2 cycles with in_valid=4'b1111 and out_ready=1 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 throughout. First edge after release loads the channel on sel.
- Explicit select: MODE=0, in_data ch2=16'hBEEF, in_valid=4'b0100, sel=2, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=16'hBEEF, out_chan=2, out_valid=1. With sel=1 instead -> in_ready=0, and out_valid=0 next cycle.
- Backpressure: out_valid=1 holding 16'h1234, out_ready=0 for 3 cycles, ch0 valid with 16'h5555 -> in_ready=0 and out_data stays 16'h1234 all 3 cycles. When out_ready rises, 16'h5555 is loaded on the same edge with no bubble.
- Round-robin fairness: MODE=1, in_valid=4'b1111 held, out_ready=1 -> out_chan sequence 0,1,2,3,0 over 5 cycles. Then in_valid=4'b1010 -> sequence 1,3,1.
- Pointer hold and non-power-of-two wrap: MODE=1, CHANNELS=3, all valid, out_ready toggled 1,0,0,1 -> out_chan 0, held, held, 1. Continuing gives 2,0, wrapping modulo 3, never index 3.
- Error flag (MUX_SEL_ERR_EN defined): MODE=0, CHANNELS=3, sel=3, out_valid=0 -> sel_err=1 for exactly one cycle, in_ready=0, out_valid=0.
